fifo_ctrl: RTL and testbench

- Pointer, flag and write-enable controller that sequences a DEPTH-entry storage array built from the team's reset flip-flop cells, forming a synchronous single-clock FIFO.
- Accepts push and pop requests and decides which are accepted.
- Drives write enable and write/read addresses to the storage array.
- Reports occupancy, full/empty, threshold flags and sticky overflow/underflow errors.
- Contains no data path. Storage and the read mux live outside this block.

---
 rtl/fifo_ctrl.sv | 85 ++++++++
 tb/tb_fifo_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl.sv
// Pointer, flag and write-enable sequencer for a single-clock FIFO whose
// storage array and read mux sit outside this block.
module fifo_ctrl #(
  parameter int DEPTH     = 8,
  parameter int ADDR_W    = 3,
  parameter int AF_THRESH = 6,
  parameter int AE_THRESH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req,
  input  logic              rd_req,
  input  logic              err_clr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_CNT   = (ADDR_W+1)'(AF_THRESH);
  localparam logic [ADDR_W:0] AE_CNT   = (ADDR_W+1)'(AE_THRESH);

  logic [ADDR_W:0] wr_ptr_reg, rd_ptr_reg, count_reg, count_next;
  logic            overflow_reg, underflow_reg;
  logic            overflow_next, underflow_next;

  // Flags decode the registered occupancy, so they track the state after each edge.
  assign empty        = (count_reg == '0);
  assign full         = (count_reg == FULL_CNT);
  assign almost_full  = (count_reg >= AF_CNT);
  assign almost_empty = (count_reg <= AE_CNT);

  // A full FIFO still takes a push when a pop frees a slot on the same edge;
  // an empty FIFO never bypasses, so the pop is refused there.
  assign rd_ack = ~rst & rd_req & ~empty;
  assign wr_en  = ~rst & wr_req & (~full | rd_ack);

  assign wr_addr   = wr_ptr_reg[ADDR_W-1:0];
  assign rd_addr   = rd_ptr_reg[ADDR_W-1:0];
  assign count     = count_reg;
  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;

  always_comb begin
    count_next = count_reg;
    case ({wr_en, rd_ack})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // A new error on the clearing edge keeps the flag set.
  assign overflow_next  = (wr_req & ~wr_en)  | (overflow_reg  & ~err_clr);
  assign underflow_next = (rd_req & ~rd_ack) | (underflow_reg & ~err_clr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_reg + {{ADDR_W{1'b0}}, wr_en};
      rd_ptr_reg    <= rd_ptr_reg + {{ADDR_W{1'b0}}, rd_ack};
      count_reg     <= count_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  // Occupancy must always equal the pointer distance modulo 2*DEPTH.
  a_count_matches_ptrs : assert property (@(posedge clk) disable iff (rst)
    count_reg == (wr_ptr_reg - rd_ptr_reg));

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed-vector bench for fifo_ctrl with an external flop array and a
// queue scoreboard for data ordering.
module tb_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst, wr_req, rd_req, err_clr;
  logic       wr_en, rd_ack, full, empty, almost_full, almost_empty;
  logic       overflow, underflow;
  logic [2:0] wr_addr, rd_addr;
  logic [3:0] count;
  logic [7:0] wdata;
  logic [7:0] mem [8];
  logic [7:0] rd_data;
  logic [7:0] q [$];
  logic [7:0] exp_word;
  int         vec_cnt = 0;
  int         err_cnt = 0;

  always #5 clk = ~clk;

  fifo_ctrl #(.DEPTH(8), .ADDR_W(3), .AF_THRESH(6), .AE_THRESH(2)) dut (
    .clk(clk), .rst(rst), .wr_req(wr_req), .rd_req(rd_req), .err_clr(err_clr),
    .wr_en(wr_en), .wr_addr(wr_addr), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .count(count), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .overflow(overflow), .underflow(underflow)
  );

  always @(posedge clk) if (wr_en) mem[wr_addr] <= wdata;
  assign rd_data = mem[rd_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_flags(input string tag, input logic [3:0] c, input logic e,
                            input logic f, input logic af, input logic ae);
    check({tag, ".count"}, 32'(count), 32'(c));
    check({tag, ".empty"}, 32'(empty), 32'(e));
    check({tag, ".full"}, 32'(full), 32'(f));
    check({tag, ".almost_full"}, 32'(almost_full), 32'(af));
    check({tag, ".almost_empty"}, 32'(almost_empty), 32'(ae));
  endtask

  initial begin
    rst = 1'b1; wr_req = 1'b1; rd_req = 1'b1; err_clr = 1'b0; wdata = 8'h00;
    step(); step();
    check("rst.wr_en", 32'(wr_en), 32'd0);
    check("rst.rd_ack", 32'(rd_ack), 32'd0);
    wr_req = 1'b0; rd_req = 1'b0;
    rst = 1'b0;
    step();
    idle_flags("reset", 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("reset.wr_addr", 32'(wr_addr), 32'd0);
    check("reset.rd_addr", 32'(rd_addr), 32'd0);
    check("reset.overflow", 32'(overflow), 32'd0);
    check("reset.underflow", 32'(underflow), 32'd0);

    // Fill: eight pushes
    for (int i = 0; i < 8; i++) begin
      wr_req = 1'b1; wdata = 8'h10 + 8'(i);
      #1;
      check("fill.wr_en", 32'(wr_en), 32'd1);
      check("fill.wr_addr", 32'(wr_addr), 32'(i));
      q.push_back(wdata);
      step();
      idle_flags("fill", 4'(i + 1), 1'b0, (i == 7), (i + 1 >= 6), (i + 1 <= 2));
      $display("push %0d data %0h count %0d", i, wdata, count);
    end
    wr_req = 1'b0;
    check("fill.wr_addr_wrap", 32'(wr_addr), 32'd0);

    // Full, push only -> rejected, overflow set, then cleared
    wr_req = 1'b1; #1;
    check("ovf.wr_en", 32'(wr_en), 32'd0);
    step();
    wr_req = 1'b0;
    check("ovf.count", 32'(count), 32'd8);
    check("ovf.flag", 32'(overflow), 32'd1);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    check("ovf.cleared", 32'(overflow), 32'd0);
    $display("overflow set and cleared");

    // Full, push and pop together
    wr_req = 1'b1; rd_req = 1'b1; wdata = 8'h20; #1;
    check("fullrw.wr_en", 32'(wr_en), 32'd1);
    check("fullrw.rd_ack", 32'(rd_ack), 32'd1);
    exp_word = q.pop_front();
    check("fullrw.rd_data", 32'(rd_data), 32'(exp_word));
    q.push_back(wdata);
    step();
    wr_req = 1'b0; rd_req = 1'b0;
    check("fullrw.count", 32'(count), 32'd8);
    check("fullrw.wr_addr", 32'(wr_addr), 32'd1);
    check("fullrw.rd_addr", 32'(rd_addr), 32'd1);
    check("fullrw.overflow", 32'(overflow), 32'd0);
    $display("full push+pop count %0d", count);

    // Drain, checking order
    for (int i = 0; i < 8; i++) begin
      rd_req = 1'b1; #1;
      check("drain.rd_ack", 32'(rd_ack), 32'd1);
      exp_word = q.pop_front();
      check("drain.rd_data", 32'(rd_data), 32'(exp_word));
      step();
      check("drain.count", 32'(count), 32'(7 - i));
      $display("pop %0d data %0h count %0d", i, exp_word, count);
    end
    rd_req = 1'b0;
    idle_flags("drained", 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("drained.underflow", 32'(underflow), 32'd0);

    // Empty, push and pop together -> push only, underflow set
    wr_req = 1'b1; rd_req = 1'b1; wdata = 8'h30; #1;
    check("emptyrw.rd_ack", 32'(rd_ack), 32'd0);
    check("emptyrw.wr_en", 32'(wr_en), 32'd1);
    q.push_back(wdata);
    step();
    wr_req = 1'b0;
    check("emptyrw.count", 32'(count), 32'd1);
    check("emptyrw.underflow", 32'(underflow), 32'd1);
    #1;
    check("emptyrw.pop_ack", 32'(rd_ack), 32'd1);
    exp_word = q.pop_front();
    check("emptyrw.rd_data", 32'(rd_data), 32'(exp_word));
    step();
    rd_req = 1'b0;
    check("emptyrw.count0", 32'(count), 32'd0);
    check("emptyrw.empty", 32'(empty), 32'd1);
    $display("empty push+pop handled, underflow %0d", underflow);

    // err_clr with a new underflow on the same edge -> stays set
    rd_req = 1'b1; err_clr = 1'b1; step();
    check("setwins.underflow", 32'(underflow), 32'd1);
    rd_req = 1'b0; step(); err_clr = 1'b0;
    check("clr.underflow", 32'(underflow), 32'd0);

    // Preload three words, then alternate push/pop
    for (int i = 0; i < 3; i++) begin
      wr_req = 1'b1; wdata = 8'h40 + 8'(i); q.push_back(wdata); step();
    end
    wr_req = 1'b0;
    check("pre.count", 32'(count), 32'd3);
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) begin
        wr_req = 1'b1; rd_req = 1'b0; wdata = 8'h50 + 8'(i); q.push_back(wdata);
      end else begin
        wr_req = 1'b0; rd_req = 1'b1; #1;
        exp_word = q.pop_front();
        check("alt.rd_data", 32'(rd_data), 32'(exp_word));
      end
      step();
      idle_flags("alt", (i % 2 == 0) ? 4'd4 : 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
      $display("alt %0d wr_addr %0d rd_addr %0d count %0d", i, wr_addr, rd_addr, count);
    end
    wr_req = 1'b0; rd_req = 1'b0;
    check("alt.overflow", 32'(overflow), 32'd0);
    check("alt.underflow", 32'(underflow), 32'd0);

    // Mid-stream asynchronous reset at count 5
    for (int i = 0; i < 2; i++) begin
      wr_req = 1'b1; wdata = 8'h60 + 8'(i); step();
    end
    wr_req = 1'b0;
    check("mid.count5", 32'(count), 32'd5);
    rst = 1'b1; #1;
    idle_flags("midrst", 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("midrst.wr_addr", 32'(wr_addr), 32'd0);
    check("midrst.rd_addr", 32'(rd_addr), 32'd0);
    $display("async reset mid-stream count %0d", count);
    step();
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
